// File: rtl/proc_pkg.sv
// Shared constants and types for the proc_sequencer datapath slice:
// default datapath width, opcode values and the T0..T3 state encoding.
package proc_pkg;

  localparam int DATA_W_DEF = 16;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  // Instruction register layout: III XXX YYY (opcode, dest Rx, source Ry).
  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rx;
    logic [2:0] ry;
  } instr_t;

endpackage

// File: rtl/regn.sv
// Plain DATA_W-bit register with load enable and asynchronous active-low
// clear; used for R0..R7, A and G.
module regn
  import proc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;

  always_comb begin
    data_d = en ? d : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/proc_sequencer.sv
// Multi-cycle instruction sequencer (mv, mvi, add, optional sub) around an
// external ALU. Define PROC_SUB_EN to execute opcode 011 as subtract.
module proc_sequencer
  import proc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLOCK_50,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] alu_rx,
  output logic [DATA_W-1:0] alu_ry,
  output logic              alu_addsub,
  output logic [DATA_W-1:0] BusWires,
  output logic              Done
);

  state_t            state_q, state_d;
  instr_t            ir_q, ir_d;

  logic [7:0]        r_en;
  logic              a_en;
  logic              g_en;
  logic [DATA_W-1:0] r_q [8];
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] g_q;
  logic [DATA_W-1:0] bus_val;
  logic              done_val;
  logic              addsub_val;
  logic              sub_op;
  logic              arith_op;

`ifdef PROC_SUB_EN
  assign sub_op = (ir_q.op == OP_SUB);
`else
  assign sub_op = 1'b0;
`endif

  assign arith_op = (ir_q.op == OP_ADD) || sub_op;

  // Control decode: next state, IR capture, bus source and write enables.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    bus_val    = '0;
    r_en       = '0;
    a_en       = 1'b0;
    g_en       = 1'b0;
    done_val   = 1'b0;
    addsub_val = 1'b0;
    unique case (state_q)
      T0: begin
        if (Run) begin
          ir_d    = instr_t'(DIN[8:0]);
          state_d = T1;
        end
      end
      T1: begin
        if (arith_op) begin
          bus_val = r_q[ir_q.rx];
          a_en    = 1'b1;
          state_d = T2;
        end else begin
          done_val = 1'b1;
          state_d  = T0;
          case (ir_q.op)
            OP_MV: begin
              bus_val        = r_q[ir_q.ry];
              r_en[ir_q.rx]  = 1'b1;
            end
            OP_MVI: begin
              bus_val        = DIN;
              r_en[ir_q.rx]  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      T2: begin
        bus_val    = r_q[ir_q.ry];
        addsub_val = sub_op;
        g_en       = 1'b1;
        state_d    = T3;
      end
      T3: begin
        bus_val       = g_q;
        r_en[ir_q.rx] = 1'b1;
        done_val      = 1'b1;
        state_d       = T0;
      end
      default: state_d = T0;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_r
    regn #(.DATA_W(DATA_W)) u_r (
      .clk   (CLOCK_50),
      .rst_n (Resetn),
      .en    (r_en[i]),
      .d     (bus_val),
      .q     (r_q[i])
    );
  end

  regn #(.DATA_W(DATA_W)) u_a (
    .clk   (CLOCK_50),
    .rst_n (Resetn),
    .en    (a_en),
    .d     (bus_val),
    .q     (a_q)
  );

  // G captures the external ALU output, only during T2.
  regn #(.DATA_W(DATA_W)) u_g (
    .clk   (CLOCK_50),
    .rst_n (Resetn),
    .en    (g_en),
    .d     (alu_result),
    .q     (g_q)
  );

  assign BusWires   = bus_val;
  assign Done       = done_val;
  assign alu_addsub = addsub_val;
  assign alu_rx     = a_q;
  assign alu_ry     = bus_val;

endmodule
